// File: rtl/crypto_wallet_pio_master.sv
// rtl/crypto_wallet_pio_master.sv - command-driven Avalon-MM master for a PIO slave s1 port
// Runs WRITE, READ, RMW and POLL commands as single slave bus cycles (read latency 1).
module crypto_wallet_pio_master #(
   parameter int POLL_TIMEOUT = 1024,
   parameter int POLL_GAP     = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [1:0]  cmd_addr,
   input  logic [31:0] cmd_data,
   input  logic [31:0] cmd_mask,
   output logic        rsp_valid,
   output logic [31:0] rsp_data,
   output logic        rsp_timeout,
   output logic [1:0]  avm_address,
   output logic        avm_chipselect,
   output logic        avm_write_n,
   output logic [31:0] avm_writedata,
   input  logic [31:0] avm_readdata
);

   localparam int AW = $clog2(POLL_TIMEOUT + 1);
   localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

   localparam logic [1:0] OP_WRITE = 2'd0;
   localparam logic [1:0] OP_READ  = 2'd1;
   localparam logic [1:0] OP_POLL  = 2'd2;
   localparam logic [1:0] OP_RMW   = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE, S_WR, S_RD_ADDR, S_RD_CAP, S_RMW_WR, S_POLL_WAIT, S_RESP
   } state_t;

   state_t          state, state_nxt;
   logic [1:0]      op_q;
   logic [31:0]     data_q, mask_q;
   logic [AW-1:0]   attempts;
   logic [GW-1:0]   gap_cnt;
   logic [31:0]     merged;
   logic            poll_match, poll_last;

   assign merged     = (avm_readdata & ~mask_q) | (data_q & mask_q);
   assign poll_match = ((avm_readdata ^ data_q) & mask_q) == 32'd0;
   assign poll_last  = (attempts == AW'(POLL_TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt      = state;
      cmd_ready      = 1'b0;
      avm_chipselect = 1'b0;
      avm_write_n    = 1'b1;
      rsp_valid      = 1'b0;
      case (state)
         S_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) state_nxt = (cmd_op == OP_WRITE) ? S_WR : S_RD_ADDR;
         end
         S_WR: begin
            avm_chipselect = 1'b1;
            avm_write_n    = 1'b0;
            state_nxt      = S_RESP;
         end
         S_RD_ADDR: begin
            avm_chipselect = 1'b1;
            state_nxt      = S_RD_CAP;
         end
         S_RD_CAP: begin
            if (op_q == OP_RMW)
               state_nxt = S_RMW_WR;
            else if (op_q == OP_POLL && !poll_match && !poll_last)
               state_nxt = (POLL_GAP == 0) ? S_RD_ADDR : S_POLL_WAIT;
            else
               state_nxt = S_RESP;
         end
         S_RMW_WR: begin
            avm_chipselect = 1'b1;
            avm_write_n    = 1'b0;
            state_nxt      = S_RESP;
         end
         S_POLL_WAIT: begin
            if (gap_cnt == '0) state_nxt = S_RD_ADDR;
         end
         S_RESP: begin
            rsp_valid = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
      // Suppress the strobe while reset is held so an aborted op never lands a write.
      if (!reset_n) begin
         avm_chipselect = 1'b0;
         avm_write_n    = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         op_q          <= OP_WRITE;
         data_q        <= '0;
         mask_q        <= '0;
         attempts      <= '0;
         gap_cnt       <= '0;
         avm_address   <= '0;
         avm_writedata <= '0;
         rsp_data      <= '0;
         rsp_timeout   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  op_q        <= cmd_op;
                  data_q      <= cmd_data;
                  mask_q      <= cmd_mask;
                  avm_address <= cmd_addr;
                  attempts    <= '0;
                  rsp_timeout <= 1'b0;
                  if (cmd_op == OP_WRITE) begin
                     avm_writedata <= cmd_data;
                     rsp_data      <= cmd_data;
                  end
               end
            end
            S_RD_CAP: begin
               if (op_q == OP_RMW) begin
                  avm_writedata <= merged;
                  rsp_data      <= merged;
               end else begin
                  rsp_data <= avm_readdata;
               end
               if (op_q == OP_POLL && !poll_match) begin
                  attempts <= attempts + AW'(1);
                  gap_cnt  <= GW'(POLL_GAP - 1);
                  if (poll_last) rsp_timeout <= 1'b1;
               end
            end
            S_POLL_WAIT: gap_cnt <= gap_cnt - GW'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_crypto_wallet_pio_master.sv
// tb/tb_crypto_wallet_pio_master.sv - randomized self-checking bench with PIO slave and reference model
module tb_crypto_wallet_pio_master;
   localparam int TMO = 8;
   localparam int GAP = 4;
   localparam logic [1:0] OP_W = 2'd0, OP_R = 2'd1, OP_P = 2'd2, OP_M = 2'd3;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        cmd_valid, cmd_ready;
   logic [1:0]  cmd_op, cmd_addr;
   logic [31:0] cmd_data, cmd_mask;
   logic        rsp_valid, rsp_timeout;
   logic [31:0] rsp_data;
   logic [1:0]  avm_address;
   logic        avm_chipselect, avm_write_n;
   logic [31:0] avm_writedata;
   logic [31:0] avm_readdata = 32'd0;

   int n_checks = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   crypto_wallet_pio_master #(.POLL_TIMEOUT(TMO), .POLL_GAP(GAP)) dut (
      .clk(clk), .reset_n(reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
      .cmd_data(cmd_data), .cmd_mask(cmd_mask),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
      .avm_address(avm_address), .avm_chipselect(avm_chipselect), .avm_write_n(avm_write_n),
      .avm_writedata(avm_writedata), .avm_readdata(avm_readdata)
   );

   // PIO slave: 2-bit data and direction registers, readdata registered every cycle.
   logic [1:0] slv_reg [0:1] = '{2'b00, 2'b00};
   int slv_reads = 0;
   int arm_at = -1;
   always @(posedge clk) begin
      avm_readdata <= (avm_address < 2'd2) ? {30'b0, slv_reg[avm_address[0]]} : 32'd0;
      if (avm_chipselect && avm_write_n) slv_reads <= slv_reads + 1;
      if (avm_chipselect && !avm_write_n && avm_address < 2'd2)
         slv_reg[avm_address[0]] <= avm_writedata[1:0];
      if (arm_at >= 0 && slv_reads == arm_at) slv_reg[0][0] <= 1'b1;
   end

   // Reference model state: what the slave registers should hold.
   logic [1:0] shadow [0:1] = '{2'b00, 2'b00};

   int          lat, nwr, wr_cyc, ready_bad;
   logic [31:0] o_data, wr_data;
   logic        o_tmo;
   logic [1:0]  wr_addr;
   int          rd_cyc[$];
   logic [1:0]  rd_addr_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] shadow_rd(input logic [1:0] a);
      return (a < 2'd2) ? {30'b0, shadow[a[0]]} : 32'd0;
   endfunction

   task automatic check_reset(input string tag);
      check({tag, "_addr"}, 32'(avm_address), 32'd0);
      check({tag, "_cs"}, 32'(avm_chipselect), 32'd0);
      check({tag, "_write_n"}, 32'(avm_write_n), 32'd1);
      check({tag, "_wdata"}, avm_writedata, 32'd0);
      check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
      check({tag, "_rsp_data"}, rsp_data, 32'd0);
      check({tag, "_rsp_timeout"}, 32'(rsp_timeout), 32'd0);
      check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
   endtask

   task automatic issue(input logic [1:0] op, input logic [1:0] addr,
                        input logic [31:0] data, input logic [31:0] mask);
      @(negedge clk);
      check("idle_ready", 32'(cmd_ready), 32'd1);
      check("idle_no_rsp", 32'(rsp_valid), 32'd0);
      cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data; cmd_mask = mask;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd_op = 2'($urandom); cmd_addr = 2'($urandom); cmd_data = $urandom; cmd_mask = $urandom;
   endtask

   task automatic run_cmd(input logic [1:0] op, input logic [1:0] addr,
                          input logic [31:0] data, input logic [31:0] mask);
      issue(op, addr, data, mask);
      lat = -1; nwr = 0; wr_cyc = 0; ready_bad = 0;
      rd_cyc.delete(); rd_addr_q.delete();
      for (int c = 1; c <= 200; c++) begin
         @(negedge clk);
         if (cmd_ready) ready_bad++;
         if (avm_chipselect && !avm_write_n) begin
            nwr++; wr_addr = avm_address; wr_data = avm_writedata; wr_cyc = c;
         end
         if (avm_chipselect && avm_write_n) begin
            rd_cyc.push_back(c); rd_addr_q.push_back(avm_address);
         end
         if (rsp_valid) begin
            lat = c; o_data = rsp_data; o_tmo = rsp_timeout;
            break;
         end
      end
   endtask

   task automatic do_cmd(input logic [1:0] op, input logic [1:0] addr,
                         input logic [31:0] data, input logic [31:0] mask, input int flip);
      logic [31:0] rd, v, merged, e_rsp;
      int e_lat, e_nrd, e_nwr, k;
      logic e_tmo;
      rd = shadow_rd(addr); v = rd; merged = 32'd0;
      e_tmo = 1'b0; e_nrd = 0; e_nwr = 0; e_lat = 0; e_rsp = 32'd0; k = 0;
      case (op)
         OP_W: begin e_lat = 2; e_nwr = 1; e_rsp = data; end
         OP_R: begin e_lat = 3; e_nrd = 1; e_rsp = rd; end
         OP_M: begin
            merged = (rd & ~mask) | (data & mask);
            e_lat = 4; e_nrd = 1; e_nwr = 1; e_rsp = merged;
         end
         default: begin
            e_tmo = 1'b1; k = TMO;
            for (int i = 1; i <= TMO; i++) begin
               v = rd;
               if (flip > 0 && i > flip) v = v | 32'h1;
               if ((v & mask) == (data & mask)) begin k = i; e_tmo = 1'b0; break; end
            end
            e_nrd = k; e_lat = 3 + (k - 1) * (2 + GAP); e_rsp = v;
         end
      endcase
      if (flip > 0) arm_at = slv_reads + flip;
      run_cmd(op, addr, data, mask);
      arm_at = -1;
      check("latency", 32'(lat), 32'(e_lat));
      check("rsp_data", o_data, e_rsp);
      check("rsp_timeout", 32'(o_tmo), 32'(e_tmo));
      check("n_reads", 32'(rd_cyc.size()), 32'(e_nrd));
      check("n_writes", 32'(nwr), 32'(e_nwr));
      check("ready_while_busy", 32'(ready_bad), 32'd0);
      if (e_nwr > 0) begin
         check("wr_addr", 32'(wr_addr), 32'(addr));
         check("wr_data", wr_data, (op == OP_W) ? data : merged);
         check("wr_cycle", 32'(wr_cyc), (op == OP_W) ? 32'd1 : 32'd3);
      end
      for (int i = 0; i < rd_cyc.size() && i < e_nrd; i++) begin
         check("rd_cycle", 32'(rd_cyc[i]), 32'(1 + i * (2 + GAP)));
         check("rd_addr", 32'(rd_addr_q[i]), 32'(addr));
      end
      if (op == OP_W && addr < 2'd2) shadow[addr[0]] = data[1:0];
      if (op == OP_M && addr < 2'd2) shadow[addr[0]] = merged[1:0];
      if (op == OP_P && flip > 0 && e_nrd > flip) shadow[0][0] = 1'b1;
   endtask

   initial begin
      int seen;
      logic [1:0] op;
      logic [31:0] d, m;
      cmd_valid = 1'b0; cmd_op = 2'd0; cmd_addr = 2'd0; cmd_data = 32'd0; cmd_mask = 32'd0;
      repeat (3) @(negedge clk);
      check_reset("por");
      reset_n = 1'b1;

      do_cmd(OP_W, 2'd1, 32'h3, 32'h0, 0);
      do_cmd(OP_W, 2'd0, 32'h2, 32'h0, 0);
      do_cmd(OP_R, 2'd0, 32'h0, 32'h0, 0);
      do_cmd(OP_M, 2'd0, 32'h1, 32'h1, 0);
      do_cmd(OP_R, 2'd0, 32'h0, 32'h0, 0);
      do_cmd(OP_W, 2'd0, 32'h2, 32'h0, 0);
      do_cmd(OP_P, 2'd0, 32'h1, 32'h1, 3);
      do_cmd(OP_P, 2'd1, {30'b0, ~shadow[1]}, 32'h3, 0);
      do_cmd(OP_P, 2'd2, 32'h5, 32'h0, 0);
      do_cmd(OP_W, 2'd3, 32'hdead_beef, 32'h0, 0);
      do_cmd(OP_R, 2'd3, 32'h0, 32'h0, 0);

      // Abort a POLL while it sits in its inter-read gap.
      issue(OP_P, 2'd1, {30'b0, ~shadow[1]}, 32'h3);
      repeat (4) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      check_reset("rst_poll");
      reset_n = 1'b1;
      seen = 0;
      repeat (50) begin
         @(negedge clk);
         if (rsp_valid) seen++;
      end
      check("rst_poll_no_rsp", 32'(seen), 32'd0);

      // Abort a WRITE during its strobe cycle; the register must keep its old value.
      issue(OP_W, 2'd0, {30'b0, ~shadow[0]}, 32'h0);
      @(negedge clk);
      check("rst_wr_strobe", {30'b0, avm_chipselect, avm_write_n}, 32'h2);
      reset_n = 1'b0;
      @(negedge clk);
      check_reset("rst_wr");
      reset_n = 1'b1;
      seen = 0;
      repeat (5) begin
         @(negedge clk);
         if (rsp_valid) seen++;
      end
      check("rst_wr_no_rsp", 32'(seen), 32'd0);
      do_cmd(OP_R, 2'd0, 32'h0, 32'h0, 0);

      for (int n = 0; n < 60; n++) begin
         op = 2'($urandom_range(0, 3));
         d = $urandom;
         m = $urandom;
         if (op == OP_P) begin
            d = (d & 32'hffff_fffc) | 32'($urandom_range(0, 3));
            m = ($urandom_range(0, 3) == 0) ? 32'h0 : 32'($urandom_range(1, 3));
         end
         do_cmd(op, 2'($urandom_range(0, 3)), d, m, 0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
